dsm_cic_decimator: RTL and testbench

DSM_CIC_DECIMATOR -- requirements
Module: dsm_cic_decimator

---
 rtl/dsm_cic_decimator_if.sv | 10 +
 rtl/dsm_cic_decimator.sv | 58 +++++
 tb/tb_dsm_cic_decimator.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dsm_cic_decimator_if.sv
// dsm_cic_decimator_if: ternary modulator code stream in, decimated samples and error flag out.
interface dsm_cic_decimator_if #(parameter int ACC_W = 24);
  logic [1:0] pwm;
  logic in_valid;
  logic signed [ACC_W-1:0] dout;
  logic out_valid;
  logic err;
  modport master (output pwm, in_valid, input dout, out_valid, err);
  modport slave (input pwm, in_valid, output dout, out_valid, err);
endinterface

// File: rtl/dsm_cic_decimator.sv
// dsm_cic_decimator: third-order CIC decimator (R = DEC_RATIO, M = 1) for a ternary delta-sigma stream.
// Define DSM_DEC_ERR_EN to raise a sticky err on accepted illegal code 10.
module dsm_cic_decimator #(
  parameter int DEC_RATIO = 50,
  parameter int ACC_W = 24
) (
  input logic clock,
  input logic reset,
  dsm_cic_decimator_if.slave bus
);
  localparam int CW = $clog2(DEC_RATIO);
  logic [ACC_W-1:0] x, i1, i2, i3, d1, d2, d3, c1, c2, c3;
  logic [CW-1:0] phase;
  logic strobe, last;
  always_comb begin
    x = bus.pwm == 2'b01 ? ACC_W'(1) : bus.pwm == 2'b11 ? '1 : '0;
    last = phase == CW'(DEC_RATIO - 1);
    c1 = i3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end
  // combs read the integrator value from before this edge, so a sample accepted alongside the strobe belongs to the next block
  always_ff @(posedge clock) begin
    if (!reset) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      phase <= '0;
      strobe <= 1'b0;
      bus.dout <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        i1 <= i1 + x;
        i2 <= i2 + i1;
        i3 <= i3 + i2;
        phase <= last ? '0 : phase + CW'(1);
      end
      strobe <= bus.in_valid && last;
      bus.out_valid <= strobe;
      if (strobe) begin
        d1 <= i3;
        d2 <= c1;
        d3 <= c2;
        bus.dout <= c3;
      end
    end
  end
`ifdef DSM_DEC_ERR_EN
  always_ff @(posedge clock)
    bus.err <= !reset ? 1'b0 : bus.err | (bus.in_valid && bus.pwm == 2'b10);
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_dsm_cic_decimator.sv
// tb_dsm_cic_decimator: directed and randomized checks of the CIC decimator against a binomial-weight model.
module tb_dsm_cic_decimator;
  localparam int R = 50;
  localparam int W = 24;
`ifdef DSM_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  dsm_cic_decimator_if #(.ACC_W(W)) bus();
  dsm_cic_decimator #(.DEC_RATIO(R), .ACC_W(W)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int xs[$];
  int n = 0;
  bit exp_ov = 0, exp_err = 0, pend = 0;
  logic [W-1:0] exp_dout = '0, pend_val = '0;
  logic signed [W-1:0] got[$];
  int gt[$];

  // integrator-3 value after m accepted samples: sum of x_j * C(m-1-j, 2)
  function automatic longint s3(int m);
    longint a = 0;
    for (int j = 0; j < m; j++) a += longint'(xs[j]) * longint'((m - 1 - j) * (m - 2 - j) / 2);
    return a;
  endfunction

  function automatic int dec(logic [1:0] p);
    return p == 2'b01 ? 1 : p == 2'b11 ? -1 : 0;
  endfunction

  always @(posedge clock) begin
    longint v;
    cyc++;
    if (!reset) begin
      n = 0;
      xs.delete();
      exp_ov = 0;
      exp_dout = '0;
      exp_err = 0;
      pend = 0;
    end else begin
      exp_ov = pend;
      if (pend) exp_dout = pend_val;
      pend = 0;
      if (bus.in_valid) begin
        xs.push_back(dec(bus.pwm));
        n++;
        if (ERR_EN && bus.pwm == 2'b10) exp_err = 1;
        if (n % R == 0) begin
          v = s3(n) - 3 * s3(n - R) + 3 * s3(n - 2 * R) - s3(n - 3 * R);
          pend_val = v[W-1:0];
          pend = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    vectors++;
    if (bus.out_valid !== exp_ov || bus.err !== exp_err || bus.dout !== exp_dout) begin
      miscompares++;
      $display("FAIL cycle %0d: out_valid=%b err=%b dout=%0d, expected out_valid=%b err=%b dout=%0d",
               cyc, bus.out_valid, bus.err, bus.dout, exp_ov, exp_err, $signed(exp_dout));
    end
    if (reset && bus.out_valid === 1'b1) begin
      got.push_back(bus.dout);
      gt.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] p, input logic v);
    bus.pwm = p;
    bus.in_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step(2'($urandom), 1'b1);
    reset = 1'b1;
    got.delete();
    gt.delete();
  endtask

  task automatic chk_intervals(input string nm, input int iv);
    for (int i = 1; i < gt.size(); i++) chk(nm, gt[i] - gt[i-1], iv);
  endtask

  initial begin
    int t0;
    bus.pwm = 2'b00;
    bus.in_valid = 1'b0;
    do_reset();
    chk("reset_dout", bus.dout, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_err", bus.err, 0);

    repeat (R * 6 + 5) step(2'b01, 1'b1);
    chk("pos_count", got.size(), 6);
    chk("pos_s1", got[0], 19600);
    chk("pos_s2", got[1], 102900);
    for (int i = 3; i < 6; i++) chk("pos_settled", got[i], 125000);
    chk_intervals("pos_interval", R);

    do_reset();
    repeat (R * 6 + 5) step(2'b11, 1'b1);
    for (int i = 3; i < 6; i++) chk("neg_settled", got[i], -125000);

    do_reset();
    repeat (R * 4 + 5) step(2'b00, 1'b1);
    chk("zero_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("zero_out", got[i], 0);

    do_reset();
    for (int i = 0; i < R * 6 + 5; i++) step(i % 2 ? 2'b11 : 2'b01, 1'b1);
    for (int i = 3; i < 6; i++) chk("alt_out", got[i], 0);

    do_reset();
    for (int i = 0; i < R * 12 + 5; i++) step(2'b01, i % 2 == 0);
    chk("gap_count", got.size(), 6);
    chk("gap_s1", got[0], 19600);
    for (int i = 3; i < 6; i++) chk("gap_settled", got[i], 125000);
    chk_intervals("gap_interval", 2 * R);

    do_reset();
    for (int i = 0; i < 10; i++) step(2'b01, 1'b1);
    chk("err_before", bus.err, 0);
    step(2'b10, 1'b1);
    chk("err_set", bus.err, ERR_EN);
    for (int i = 11; i < R + 3; i++) step(2'b01, 1'b1);
    chk("illegal_s1", got[0], 19600 - 741);
    chk("err_held", bus.err, ERR_EN);

    do_reset();
    repeat (30) step(2'b01, 1'b1);
    do_reset();
    t0 = cyc + 1;
    repeat (2 * R + 20) step(2'b01, 1'b1);
    chk("rst_count", got.size(), 2);
    chk("rst_latency", gt[0] - t0, R);
    chk("rst_s1", got[0], 19600);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [1:0] p;
      r = $urandom_range(0, 63);
      p = r == 0 ? 2'b10 : r < 24 ? 2'b01 : r < 48 ? 2'b11 : 2'b00;
      if (i == 1700) do_reset();
      step(p, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
